// File: rtl/onchip_block_reader_if.sv
// Avalon-MM RAM read port plus valid/ready output stream
// for the on-chip block reader.
interface onchip_block_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic              avm_clken;
    logic [DATA_W-1:0] avm_readdata;

    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write,
        output avm_byteenable,
        output avm_clken,
        input  avm_readdata,
        output st_data,
        output st_valid,
        input  st_ready
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write,
        input  avm_byteenable,
        input  avm_clken,
        output avm_readdata,
        input  st_data,
        input  st_valid,
        output st_ready
    );
endinterface

// File: rtl/onchip_block_reader.sv
// Sequential block reader: issues single-word RAM reads and
// streams the returned words in order through a small FIFO.
module onchip_block_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    output logic                  busy,
    output logic                  done,
    onchip_block_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W:0]   out_cnt;
    logic              inflight;
    logic              busy_q;
    logic              done_q;
    logic              done_nxt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  occ;

    logic accept;
    logic launch;
    logic pop;
    logic last_issue;
    logic last_pop;

    assign accept = (state == IDLE) && start
                 && (word_count != '0);
    assign pop    = bus.st_valid && bus.st_ready;

    // Occupancy after this cycle's pop, counting the read whose
    // data lands at the end of this cycle; a new read needs a slot.
    assign occ    = fifo_cnt - CNT_W'(pop)
                  + CNT_W'(inflight);
    assign launch = (state == ISSUE)
                 && (occ < CNT_W'(FIFO_DEPTH));

    assign last_issue = launch && (issue_cnt == ONE);
    assign last_pop   = pop && (out_cnt == ONE);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && word_count == '0) begin
                    done_nxt = 1'b1;
                end else if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inflight  <= 1'b0;
            addr_q    <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            busy_q   <= (state_nxt != IDLE);
            done_q   <= done_nxt;
            inflight <= launch;
            if (accept) begin
                addr_q    <= base_addr;
                issue_cnt <= word_count;
                out_cnt   <= word_count;
            end else begin
                if (launch) begin
                    addr_q    <= addr_q + ADDR_W'(1);
                    issue_cnt <= issue_cnt - ONE;
                end
                if (pop) begin
                    out_cnt <= out_cnt - ONE;
                end
            end
        end
    end

    // Returning data is written unconditionally; the issue
    // throttle above guarantees a free slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (inflight) begin
                mem[wr_ptr] <= bus.avm_readdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(inflight)
                      - CNT_W'(pop);
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = launch;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_clken      = 1'b1;
    assign bus.st_data        = mem[rd_ptr];
    assign bus.st_valid       = (fifo_cnt != '0);
endmodule

// File: tb/tb_onchip_block_reader.sv
// Scoreboard bench for onchip_block_reader: a RAM model, a
// queue-based reference of expected words/addresses and a monitor.
module tb_onchip_block_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int WORDS  = 1 << ADDR_W;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic              start   = 1'b0;
    logic [ADDR_W-1:0] base_addr  = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy;
    logic              done;

    onchip_block_reader_if #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) bus ();

    onchip_block_reader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [WORDS];

    always @(posedge clk) begin
        if (bus.avm_chipselect) begin
            bus.avm_readdata <= ram[bus.avm_address];
        end
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    longint start_cyc = 0;
    int     rmode     = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.st_ready = 1'b1;
                1: bus.st_ready = ((cyc - start_cyc) % 4 == 0)
                               || ((cyc - start_cyc) % 4 == 3);
                default: bus.st_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic [DATA_W-1:0] exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];

    int t_chk = 0, t_pass = 0;
    int m_chk = 0, m_pass = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        t_chk++;
        if (act == exp) t_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic mchk(input string nm, input longint act,
                        input longint exp);
        m_chk++;
        if (act == exp) m_pass++;
        else $display("FAIL %s: got %0d, want %0d @cyc %0d",
                      nm, act, exp, cyc);
    endtask

    int     cs_cnt = 0, xfer_cnt = 0, done_cnt = 0, busy_cyc = 0;
    int     issued = 0, popped = 0, base_off = 0, m_pop = 0;
    longint last_rise = 0, done_at = 0;
    logic   prev_valid = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            m_pop = int'(bus.st_valid && bus.st_ready);
            if (bus.avm_chipselect) begin
                cs_cnt++;
                issued++;
                mchk("read_expected", longint'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0)
                    mchk("read_addr", bus.avm_address, addr_q.pop_front());
                mchk("outstanding_le_depth",
                     longint'((issued - popped - m_pop - base_off) <= DEPTH), 1);
            end
            if (m_pop != 0) begin
                popped++;
                xfer_cnt++;
                mchk("word_expected", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    mchk("st_data", bus.st_data, exp_q.pop_front());
            end
            if (bus.st_valid && !prev_valid) last_rise = cyc;
            prev_valid = bus.st_valid;
            if (busy) busy_cyc++;
            if (done) begin
                done_cnt++;
                done_at = cyc;
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic run(input int base, input int cnt, input int mode,
                       input bit poke, input int exp_first,
                       input int exp_done);
        int cs0, d0, b0;
        bit got;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(ram[(base + i) % WORDS]);
            addr_q.push_back(ADDR_W'((base + i) % WORDS));
        end
        @(posedge clk);
        #1;
        cs0       = cs_cnt;
        d0        = done_cnt;
        b0        = busy_cyc;
        base_off  = issued - popped;
        rmode     = mode;
        start_cyc = cyc;
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        word_count = (ADDR_W + 1)'(cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
        got   = 1'b0;
        for (int k = 0; k < cnt * 6 + 20 && !got; k++) begin
            if (poke && k == 4) begin
                start      = 1'b1;
                base_addr  = ADDR_W'($urandom);
                word_count = (ADDR_W + 1)'($urandom_range(1, WORDS));
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            got = (done_cnt != d0);
        end
        start = 1'b0;
        chk("done_seen", longint'(got), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("read_count", cs_cnt - cs0, cnt);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", addr_q.size(), 0);
        if (exp_first >= 0)
            chk("first_valid_cyc", last_rise - start_cyc, exp_first);
        if (exp_done >= 0) begin
            chk("done_cyc", done_at - start_cyc, exp_done);
            chk("busy_cycles", busy_cyc - b0, exp_done - 1);
        end
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int d0, x0, rb, rc;
        for (int i = 0; i < WORDS; i++) ram[i] = DATA_W'(i * 3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", bus.avm_chipselect, 0);
        chk("rst_addr", bus.avm_address, 0);
        chk("rst_valid", bus.st_valid, 0);
        chk("rst_data", bus.st_data, 0);
        chk("avm_write", bus.avm_write, 0);
        chk("avm_be", bus.avm_byteenable, 15);
        chk("avm_clken", bus.avm_clken, 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        run(5, 8, 0, 0, 3, 11);
        run(1022, 4, 0, 0, 3, 7);
        run(100, 16, 1, 0, -1, -1);
        run(7, 0, 0, 0, -1, 1);
        run(0, WORDS, 0, 0, 3, WORDS + 3);
        run(200, 30, 0, 1, -1, -1);

        rb = int'($urandom_range(0, WORDS - 1));
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(ram[(rb + i) % WORDS]);
            addr_q.push_back(ADDR_W'((rb + i) % WORDS));
        end
        @(posedge clk);
        #1;
        x0 = xfer_cnt;
        d0 = done_cnt;
        base_off   = issued - popped;
        rmode      = 0;
        start      = 1'b1;
        base_addr  = ADDR_W'(rb);
        word_count = 11'd10;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 40 && (xfer_cnt - x0) < 3; k++) begin
            @(posedge clk);
            #1;
        end
        chk("three_words_out", xfer_cnt - x0, 3);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cs", bus.avm_chipselect, 0);
        chk("mid_rst_addr", bus.avm_address, 0);
        chk("mid_rst_valid", bus.st_valid, 0);
        chk("mid_rst_data", bus.st_data, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        base_off = issued - popped;
        repeat (3) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt - d0, 0);
        run(0, 2, 0, 0, 3, 5);

        for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
        for (int n = 0; n < 10; n++) begin
            rb = int'($urandom_range(0, WORDS - 1));
            rc = int'($urandom_range(1, 40));
            run(rb, rc, int'($urandom_range(0, 2)), 0, -1, -1);
        end

        $display("%0d/%0d checks passed", t_pass + m_pass, t_chk + m_chk);
        $finish;
    end
endmodule
